// File: rtl/arm_core_pkg.sv
// Shared types and constants for the core's load/store multiple path.
package arm_core_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    localparam int unsigned WORD_BYTES    = 4;
    localparam logic [3:0]  AHB_SIZE_WORD = 4'h2;

    // Register ids are 5 bits wide to match the decoder's rd_id/rd2_id.
    localparam int unsigned REG_ID_W = 5;
    typedef logic [REG_ID_W-1:0] reg_id_t;

endpackage

// File: rtl/ldm_stm_sequencer_lsb_index16.sv
// Lowest-set-bit priority encoder over a 16-bit register list.
module lsb_index16 (
    input  logic [15:0] vec_i,
    output logic [3:0]  index_o,
    output logic        valid_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index_o = '0;
        valid_o = |vec_i;
        for (int unsigned i = 0; i < 16; i++) begin
            if (vec_i[15 - i]) begin
                index_o = 4'(15 - i);
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: one word beat per listed register,
// ascending order, followed by optional base writeback.
module ldm_stm_sequencer
    import arm_core_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_BYTES = arm_core_pkg::WORD_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [3:0]        rn,
    input  logic [ADDR_W-1:0] base,
    input  logic              p,
    input  logic              u,
    input  logic              w,
    input  logic              l,
    input  logic              AHB_ready,
    input  logic              AHB_error,
    input  logic [ADDR_W-1:0] AHB_rdata,
    output logic [ADDR_W-1:0] AHB_addr,
    output logic [4:0]        AHB_wdata_id,
    output logic              AHB_rd_en,
    output logic              AHB_wr_en,
    output logic [3:0]        AHB_size,
    output logic              rd_en,
    output logic [4:0]        rd_id,
    output logic [ADDR_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              abort
);

    seq_state_t        state_q;
    logic [15:0]       rem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wb_val_q;
    logic [3:0]        rn_q;
    logic [3:0]        cur_q;
    logic              l_q;
    logic              wb_en_q;
    logic              rd_req_q;
    logic              wr_req_q;
    logic [3:0]        size_q;
    logic              busy_q;
    logic              done_q;
    logic              abort_q;

    logic [4:0]        n_d;
    logic [ADDR_W-1:0] stride_d;
    logic [ADDR_W-1:0] span_d;
    logic [ADDR_W-1:0] start_addr_d;
    logic [ADDR_W-1:0] wb_val_d;
    logic [15:0]       rem_d;
    logic [15:0]       enc_in_d;
    logic [3:0]        enc_idx;
    logic              enc_vld;
    logic              beat_ok_d;

    // Command decode: popcount, start address and writeback value.
    always_comb begin
        n_d = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            n_d = n_d + 5'(reg_list[i]);
        end
        stride_d = ADDR_W'(WORD_BYTES);
        span_d   = ADDR_W'(n_d) * stride_d;
        case ({p, u})
            2'b01:   start_addr_d = base;
            2'b11:   start_addr_d = base + stride_d;
            2'b00:   start_addr_d = base - span_d + stride_d;
            default: start_addr_d = base - span_d;
        endcase
        wb_val_d = u ? (base + span_d) : (base - span_d);
    end

    // The single encoder picks the first beat in IDLE and the next beat while
    // a beat is being accepted, so the following beat registers with no bubble.
    always_comb begin
        beat_ok_d = (state_q == S_XFER) && AHB_ready && !AHB_error;
        rem_d     = rem_q & ~(16'd1 << cur_q);
        enc_in_d  = (state_q == S_IDLE) ? reg_list : rem_d;
    end

    lsb_index16 u_lsb (
        .vec_i   (enc_in_d),
        .index_o (enc_idx),
        .valid_o (enc_vld)
    );

    // Sequencer FSM with registered bus and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            addr_q   <= '0;
            wb_val_q <= '0;
            rn_q     <= '0;
            cur_q    <= '0;
            l_q      <= 1'b0;
            wb_en_q  <= 1'b0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            size_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rem_q    <= reg_list;
                        rn_q     <= rn;
                        l_q      <= l;
                        wb_val_q <= wb_val_d;
                        wb_en_q  <= w && !(l && reg_list[rn]);
                        if (n_d != '0) begin
                            state_q  <= S_XFER;
                            addr_q   <= start_addr_d;
                            cur_q    <= enc_idx;
                            rd_req_q <= l;
                            wr_req_q <= !l;
                            size_q   <= AHB_SIZE_WORD;
                            busy_q   <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            abort_q <= 1'b0;
                        end
                    end
                end
                S_XFER: begin
                    if (AHB_error || (AHB_ready && !enc_vld)) begin
                        addr_q   <= '0;
                        cur_q    <= '0;
                        rd_req_q <= 1'b0;
                        wr_req_q <= 1'b0;
                        size_q   <= '0;
                        if (!AHB_error) begin
                            rem_q <= rem_d;
                        end
                        if (!AHB_error && wb_en_q) begin
                            state_q <= S_WB;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            abort_q <= AHB_error;
                        end
                    end else if (AHB_ready) begin
                        rem_q  <= rem_d;
                        addr_q <= addr_q + stride_d;
                        cur_q  <= enc_idx;
                    end
                end
                S_WB: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    abort_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    abort_q <= 1'b0;
                end
            endcase
        end
    end

    // Register-file write port: load data passes through in the accepting
    // cycle so the id always matches the beat on the bus.
    always_comb begin
        rd_en   = 1'b0;
        rd_id   = '0;
        rd_data = '0;
        if (beat_ok_d && l_q) begin
            rd_en   = 1'b1;
            rd_id   = reg_id_t'({1'b0, cur_q});
            rd_data = AHB_rdata;
        end else if (state_q == S_WB) begin
            rd_en   = 1'b1;
            rd_id   = reg_id_t'({1'b0, rn_q});
            rd_data = wb_val_q;
        end
    end

    assign AHB_addr     = addr_q;
    assign AHB_wdata_id = {1'b0, cur_q};
    assign AHB_rd_en    = rd_req_q;
    assign AHB_wr_en    = wr_req_q;
    assign AHB_size     = size_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign abort        = abort_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed, table-driven bench for ldm_stm_sequencer.
module tb_ldm_stm_sequencer;

    typedef struct {
        logic        st;
        logic [15:0] rl;
        logic [3:0]  rn;
        logic [31:0] base;
        logic [3:0]  puwl;
        logic        rdy;
        logic        err;
        logic [31:0] rdata;
        logic [1:0]  bus;   // {AHB_rd_en, AHB_wr_en}
        logic [31:0] addr;
        logic [4:0]  wid;
        logic        rde;
        logic [4:0]  rid;
        logic [31:0] rdd;
        logic [2:0]  bda;   // {busy, done, abort}
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] reg_list;
    logic [3:0]  rn;
    logic [31:0] base;
    logic        p, u, w, l;
    logic        AHB_ready;
    logic        AHB_error;
    logic [31:0] AHB_rdata;
    logic [31:0] AHB_addr;
    logic [4:0]  AHB_wdata_id;
    logic        AHB_rd_en;
    logic        AHB_wr_en;
    logic [3:0]  AHB_size;
    logic        rd_en;
    logic [4:0]  rd_id;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        abort;

    int checks   = 0;
    int failures = 0;
    int row      = -1;
    vec_t tbl[$];

    ldm_stm_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .reg_list     (reg_list),
        .rn           (rn),
        .base         (base),
        .p            (p),
        .u            (u),
        .w            (w),
        .l            (l),
        .AHB_ready    (AHB_ready),
        .AHB_error    (AHB_error),
        .AHB_rdata    (AHB_rdata),
        .AHB_addr     (AHB_addr),
        .AHB_wdata_id (AHB_wdata_id),
        .AHB_rd_en    (AHB_rd_en),
        .AHB_wr_en    (AHB_wr_en),
        .AHB_size     (AHB_size),
        .rd_en        (rd_en),
        .rd_id        (rd_id),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .abort        (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic [15:0] rl, input logic [3:0] rnv,
                                input logic [31:0] b, input logic [3:0] puwl,
                                input logic rdy, input logic err, input logic [31:0] rdata,
                                input logic [1:0] bus, input logic [31:0] addr, input logic [4:0] wid,
                                input logic rde, input logic [4:0] rid, input logic [31:0] rdd,
                                input logic [2:0] bda);
        vec_t v;
        v.st = st; v.rl = rl; v.rn = rnv; v.base = b; v.puwl = puwl;
        v.rdy = rdy; v.err = err; v.rdata = rdata;
        v.bus = bus; v.addr = addr; v.wid = wid;
        v.rde = rde; v.rid = rid; v.rdd = rdd; v.bda = bda;
        return v;
    endfunction

    function automatic vec_t cyc(input logic rdy, input logic err, input logic [31:0] rdata,
                                 input logic [1:0] bus, input logic [31:0] addr, input logic [4:0] wid,
                                 input logic rde, input logic [4:0] rid, input logic [31:0] rdd,
                                 input logic [2:0] bda);
        return mk(1'b0, 16'h0, 4'h0, 32'h0, 4'b0000, rdy, err, rdata, bus, addr, wid, rde, rid, rdd, bda);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h exp=%h", name, row, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".AHB_addr"},     AHB_addr,     32'h0);
        chk({tag, ".AHB_wdata_id"}, 32'(AHB_wdata_id), 32'h0);
        chk({tag, ".AHB_rd_en"},    32'(AHB_rd_en), 32'h0);
        chk({tag, ".AHB_wr_en"},    32'(AHB_wr_en), 32'h0);
        chk({tag, ".AHB_size"},     32'(AHB_size),  32'h0);
        chk({tag, ".rd_en"},        32'(rd_en),     32'h0);
        chk({tag, ".rd_id"},        32'(rd_id),     32'h0);
        chk({tag, ".rd_data"},      rd_data,        32'h0);
        chk({tag, ".busy"},         32'(busy),      32'h0);
        chk({tag, ".done"},         32'(done),      32'h0);
        chk({tag, ".abort"},        32'(abort),     32'h0);
    endtask

    task automatic drive(input vec_t v);
        start     = v.st;
        reg_list  = v.rl;
        rn        = v.rn;
        base      = v.base;
        {p, u, w, l} = v.puwl;
        AHB_ready = v.rdy;
        AHB_error = v.err;
        AHB_rdata = v.rdata;
    endtask

    task automatic check_row(input vec_t v);
        chk("AHB_rd_en",    32'(AHB_rd_en),    32'(v.bus[1]));
        chk("AHB_wr_en",    32'(AHB_wr_en),    32'(v.bus[0]));
        chk("AHB_addr",     AHB_addr,          v.addr);
        chk("AHB_wdata_id", 32'(AHB_wdata_id), 32'(v.wid));
        chk("AHB_size",     32'(AHB_size),     (v.bus != 2'b00) ? 32'h2 : 32'h0);
        chk("rd_en",        32'(rd_en),        32'(v.rde));
        chk("rd_id",        32'(rd_id),        32'(v.rid));
        chk("rd_data",      rd_data,           v.rdd);
        chk("busy",         32'(busy),         32'(v.bda[2]));
        chk("done",         32'(done),         32'(v.bda[1]));
        chk("abort",        32'(abort),        32'(v.bda[0]));
    endtask

    initial begin
        vec_t z;
        z = cyc(1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0, 3'b000);

        // A: STMIA r0!,{r1,r3,r5} base 0x1000, zero wait; start while busy ignored
        tbl.push_back(mk(1, 16'h002A, 4'd0, 32'h1000, 4'b0110, 1, 0, 32'h0, 2'b00, 32'h0,    5'd0, 0, 5'd0, 32'h0,    3'b000));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b01, 32'h1000, 5'd1, 0, 5'd0, 32'h0,    3'b100));
        tbl.push_back(mk(1, 16'hFFFF, 4'd7, 32'h9999, 4'b0001, 1, 0, 32'h0, 2'b01, 32'h1004, 5'd3, 0, 5'd0, 32'h0, 3'b100));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b01, 32'h1008, 5'd5, 0, 5'd0, 32'h0,    3'b100));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b00, 32'h0,    5'd0, 1, 5'd0, 32'h100C, 3'b100));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b00, 32'h0,    5'd0, 0, 5'd0, 32'h0,    3'b010));
        // B: LDMDB r2,{r0,r15} base 0x2000, two wait states per beat
        tbl.push_back(mk(1, 16'h8001, 4'd2, 32'h2000, 4'b1001, 0, 0, 32'h0, 2'b00, 32'h0, 5'd0, 0, 5'd0, 32'h0, 3'b000));
        tbl.push_back(cyc(0, 0, 32'h1234_5678, 2'b10, 32'h1FF8, 5'd0,  0, 5'd0,  32'h0,         3'b100));
        tbl.push_back(cyc(0, 0, 32'h8765_4321, 2'b10, 32'h1FF8, 5'd0,  0, 5'd0,  32'h0,         3'b100));
        tbl.push_back(cyc(1, 0, 32'hAAAA_0000, 2'b10, 32'h1FF8, 5'd0,  1, 5'd0,  32'hAAAA_0000, 3'b100));
        tbl.push_back(cyc(0, 0, 32'h5555_5555, 2'b10, 32'h1FFC, 5'd15, 0, 5'd0,  32'h0,         3'b100));
        tbl.push_back(cyc(0, 0, 32'h0,         2'b10, 32'h1FFC, 5'd15, 0, 5'd0,  32'h0,         3'b100));
        tbl.push_back(cyc(1, 0, 32'hBBBB_000F, 2'b10, 32'h1FFC, 5'd15, 1, 5'd15, 32'hBBBB_000F, 3'b100));
        tbl.push_back(cyc(1, 0, 32'h0,         2'b00, 32'h0,    5'd0,  0, 5'd0,  32'h0,         3'b010));
        // C: LDMIA r4!,{r4,r6} base 0x3000, writeback suppressed
        tbl.push_back(mk(1, 16'h0050, 4'd4, 32'h3000, 4'b0111, 1, 0, 32'h0, 2'b00, 32'h0, 5'd0, 0, 5'd0, 32'h0, 3'b000));
        tbl.push_back(cyc(1, 0, 32'h4444_4444, 2'b10, 32'h3000, 5'd4, 1, 5'd4, 32'h4444_4444, 3'b100));
        tbl.push_back(cyc(1, 0, 32'h6666_6666, 2'b10, 32'h3004, 5'd6, 1, 5'd6, 32'h6666_6666, 3'b100));
        tbl.push_back(cyc(1, 0, 32'h0,         2'b00, 32'h0,    5'd0, 0, 5'd0, 32'h0,         3'b010));
        // D: STMIA r4!,{r4} base 0x4000, writeback still performed
        tbl.push_back(mk(1, 16'h0010, 4'd4, 32'h4000, 4'b0110, 1, 0, 32'h0, 2'b00, 32'h0, 5'd0, 0, 5'd0, 32'h0, 3'b000));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b01, 32'h4000, 5'd4, 0, 5'd0, 32'h0,    3'b100));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b00, 32'h0,    5'd0, 1, 5'd4, 32'h4004, 3'b100));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b00, 32'h0,    5'd0, 0, 5'd0, 32'h0,    3'b010));
        // E: empty list
        tbl.push_back(mk(1, 16'h0000, 4'd3, 32'h5000, 4'b0110, 1, 0, 32'h0, 2'b00, 32'h0, 5'd0, 0, 5'd0, 32'h0, 3'b000));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b00, 32'h0, 5'd0, 0, 5'd0, 32'h0, 3'b010));
        // F: LDMIB r1!,{r2,r3,r7,r9} base 0x6000, error on the 2nd beat
        tbl.push_back(mk(1, 16'h028C, 4'd1, 32'h6000, 4'b1111, 1, 0, 32'h0, 2'b00, 32'h0, 5'd0, 0, 5'd0, 32'h0, 3'b000));
        tbl.push_back(cyc(1, 0, 32'h2222_2222, 2'b10, 32'h6004, 5'd2, 1, 5'd2, 32'h2222_2222, 3'b100));
        tbl.push_back(cyc(1, 1, 32'h3333_3333, 2'b10, 32'h6008, 5'd3, 0, 5'd0, 32'h0,         3'b100));
        tbl.push_back(cyc(1, 0, 32'h0,         2'b00, 32'h0,    5'd0, 0, 5'd0, 32'h0,         3'b011));
        // G: STMDA r13!,{r0,r1,r2} base 0x4, address wraps through zero
        tbl.push_back(mk(1, 16'h0007, 4'd13, 32'h0000_0004, 4'b0010, 1, 0, 32'h0, 2'b00, 32'h0, 5'd0, 0, 5'd0, 32'h0, 3'b000));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b01, 32'hFFFF_FFFC, 5'd0, 0, 5'd0,  32'h0,         3'b100));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b01, 32'h0000_0000, 5'd1, 0, 5'd0,  32'h0,         3'b100));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b01, 32'h0000_0004, 5'd2, 0, 5'd0,  32'h0,         3'b100));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b00, 32'h0,         5'd0, 1, 5'd13, 32'hFFFF_FFF8, 3'b100));
        tbl.push_back(cyc(1, 0, 32'h0, 2'b00, 32'h0,         5'd0, 0, 5'd0,  32'h0,         3'b010));
        tbl.push_back(z);

        // Reset state
        rst_n = 1'b0;
        drive(z);
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Table: drive at the falling edge, compare 1 ns later
        foreach (tbl[i]) begin
            row = i;
            drive(tbl[i]);
            #1;
            check_row(tbl[i]);
            @(negedge clk);
        end

        // Asynchronous reset during the 3rd beat of STMIA r9!,{r0-r4}
        row = 100;
        drive(mk(1, 16'h001F, 4'd9, 32'h100, 4'b0110, 1, 0, 32'h0, 2'b00, 32'h0, 5'd0, 0, 5'd0, 32'h0, 3'b000));
        @(negedge clk);
        drive(z);
        AHB_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        AHB_ready = 1'b0;
        #1;
        chk("beat3.addr",  AHB_addr,          32'h108);
        chk("beat3.id",    32'(AHB_wdata_id), 32'd2);
        chk("beat3.wr_en", 32'(AHB_wr_en),    32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean restart: LDMIA r8,{r8} base 0x200
        row = 101;
        drive(mk(1, 16'h0100, 4'd8, 32'h200, 4'b0101, 1, 0, 32'hDEAD_BEEF, 2'b00, 32'h0, 5'd0, 0, 5'd0, 32'h0, 3'b000));
        #1;
        chk("restart.idle_rd_en", 32'(rd_en), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("restart.addr",    AHB_addr,        32'h200);
        chk("restart.rd_req",  32'(AHB_rd_en),  32'd1);
        chk("restart.rd_en",   32'(rd_en),      32'd1);
        chk("restart.rd_id",   32'(rd_id),      32'd8);
        chk("restart.rd_data", rd_data,         32'hDEAD_BEEF);
        @(negedge clk);
        #1;
        chk("restart.done",  32'(done),  32'd1);
        chk("restart.abort", 32'(abort), 32'd0);
        chk("restart.rd_en_after", 32'(rd_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
